interrupt_request_controller: RTL and testbench
===============================================

Name: interrupt_request_controller

Overview:
- Sits in front of the jump control block and drives its `interrupt` input.
- Collects external interrupt lines, latches rising edges as pending, masks and prioritises them, then issues a single-cycle interrupt request.
- Tracks the in-service period until the decode-stage RET instruction is seen.
- Enforces a guard window so the jump control's return-address and flag save/restore chain is never disturbed.

Parameters:
- NUM_SRC, 4: number of external interrupt sources, 1..8.
- GUARD_CYC, 2: idle cycles after RET before a new request may issue; covers the 2-stage flag-restore delay.
- MASK_RST, 4'hF: mask value loaded on reset; bit = 1 enables that source.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset.
- irq_in  input  NUM_SRC  external interrupt lines, asynchronous, rising-edge significant.
- ins  input  24  instruction currently in decode; same bus the jump control block sees.
- mask_wr  input  1  load mask_data into mask register this cycle.
- mask_data  input  NUM_SRC  new mask value.
- interrupt  output  1  one-cycle request pulse to jump control.
- int_src_id  output  3  index of the source being serviced; valid while in_service = 1.
- in_service  output  1  high from the interrupt pulse until RET is accepted.
- pending  output  NUM_SRC  latched, not-yet-serviced edges (unmasked view).

Behaviour:
- Reset (reset = 0, async):
  - state = IDLE, pending = 0, mask = MASK_RST, interrupt = 0, in_service = 0, int_src_id = 0.
  - Synchroniser and edge registers are cleared.
  - Reset asserted mid-service abandons the service. No RET is expected afterwards.
- Edge capture:
  - edge[i] = synced[i] & ~prev[i].
  - edge[i] sets pending[i].
  - pending[i] clears only when source i is granted.
  - If a new edge on i coincides with its grant, pending[i] stays 1 (set wins).
  - A level held high produces one edge only.
- Eligibility:
  - eligible = pending & mask.
  - Priority is fixed: lowest index wins.
  - A mask change via mask_wr takes effect the cycle after the write.
  - Masked pending bits are retained.
- Control-transfer hazard: while ins[23] = 1 (JC, JNC, JZ, JNZ, JMP, RET in decode), no grant is issued. This keeps the saved return address correct.
- State machine, all transitions on rising clk:
  - IDLE: if eligible != 0 and ins[23] = 0 → ARM. Latch int_src_id = winner and clear pending[winner].
  - ARM: interrupt = 1 for exactly this cycle; in_service = 1 → SERVICE.
  - SERVICE: in_service = 1. When ins[23:19] = 5'b10000 (RET) → GUARD, load guard counter = GUARD_CYC.
  - GUARD: in_service = 0; decrement the counter; at 0 → IDLE. With GUARD_CYC = 0, GUARD lasts one cycle.
- Outputs interrupt and in_service are registered (decoded from state flops); no combinational path from irq_in.
- Further interrupts are not nested; edges arriving in SERVICE or GUARD only accumulate in pending.
- RET seen in IDLE or ARM is ignored.
- int_src_id width is fixed at 3; upper bits are 0 when NUM_SRC < 8.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined: each irq_in bit passes a 2-flop synchroniser before edge detection. irq_in rising before edge N gives pending set at edge N+2 and interrupt high in the cycle after edge N+3 (idle, no hazard).
- Undefined: irq_in feeds edge detection directly; pending is set at edge N. Only valid for sources synchronous to clk.

Test Plan:
- Reset and simple request (macro defined, mask = 4'hF, ins = 24'h000000): irq_in[2] rises → pending = 4'b0100 after 2 edges. Next: interrupt pulse of 1 cycle, int_src_id = 2, pending = 0, in_service = 1.
- Priority: irq_in[3] and irq_in[1] rise in the same cycle → first grant id = 1, pending = 4'b1000. Drive ins = 24'h800000 (RET) → in_service = 0. After GUARD_CYC = 2 idle cycles, second pulse with id = 3.
- Hazard deferral: pending[0] set while ins = 24'hC00010 (JMP) for 3 cycles → no interrupt. It issues on the first cycle after ins[23] returns to 0.
- Masking: mask_data = 4'b1110 with mask_wr, then irq_in[0] rises → pending = 4'b0001, no interrupt. Write mask = 4'hF → interrupt with id = 0.
- Set-wins collision: a new irq_in[1] edge lands on the grant cycle of source 1 → pending[1] remains 1 after the grant. A second service of id 1 follows after RET and guard.
- Async reset mid-SERVICE: pull reset low for less than one clock → in_service = 0, pending = 0, mask = 4'hF immediately. No pulse follows after release without new edges.

Source files
------------

// File: rtl/interrupt_request_controller.sv
// Interrupt request controller: edge capture, masking, fixed priority and a guarded service handshake
// in front of the jump control block. Define IRQ_SYNC_EN to add a 2-flop synchroniser on each irq_in line.
module interrupt_request_controller #(
    parameter int                 NUM_SRC   = 4,
    parameter int                 GUARD_CYC = 2,
    parameter logic [NUM_SRC-1:0] MASK_RST  = {NUM_SRC{1'b1}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [23:0]        ins,
    input  logic               mask_wr,
    input  logic [NUM_SRC-1:0] mask_data,
    output logic               interrupt,
    output logic [2:0]         int_src_id,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pending
);

    localparam int GW = (GUARD_CYC < 1) ? 1 : $clog2(GUARD_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        SERVICE,
        GUARD
    } state_t;

    state_t             state;
    logic [GW-1:0]      guard_cnt;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] irq_synced;
    logic [NUM_SRC-1:0] irq_prev_p2;
    logic [NUM_SRC-1:0] irq_rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] grant_vec;
    logic [2:0]         win_id;
    logic               grant;
    logic               is_ret;
    logic               unused_ins;

    function automatic logic [2:0] lowest_index(input logic [NUM_SRC-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] irq_sync_p0;
    logic [NUM_SRC-1:0] irq_sync_p1;

    // Stage p0/p1: metastability synchroniser for asynchronous sources
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_sync_p0 <= '0;
            irq_sync_p1 <= '0;
        end else begin
            irq_sync_p0 <= irq_in;
            irq_sync_p1 <= irq_sync_p0;
        end
    end

    assign irq_synced = irq_sync_p1;
`else
    assign irq_synced = irq_in;
`endif

    // Stage p2: previous level for rising-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_prev_p2 <= '0;
        end else begin
            irq_prev_p2 <= irq_synced;
        end
    end

    assign irq_rise   = irq_synced & ~irq_prev_p2;
    assign eligible   = pending & mask;
    assign win_id     = lowest_index(eligible);
    // Grants are held off while any control transfer sits in decode so the saved return address stays valid
    assign grant      = (state == IDLE) && (|eligible) && !ins[23];
    assign grant_vec  = grant ? (NUM_SRC'(1) << win_id) : '0;
    assign is_ret     = (ins[23:19] == 5'b10000);
    assign unused_ins = ^ins[18:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask <= MASK_RST;
        end else if (mask_wr) begin
            mask <= mask_data;
        end
    end

    // A fresh edge on the granted source re-arms it in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~grant_vec) | irq_rise;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            interrupt  <= 1'b0;
            in_service <= 1'b0;
            int_src_id <= '0;
            guard_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        state      <= ARM;
                        interrupt  <= 1'b1;
                        in_service <= 1'b1;
                        int_src_id <= win_id;
                    end
                end
                ARM: begin
                    state     <= SERVICE;
                    interrupt <= 1'b0;
                end
                SERVICE: begin
                    if (is_ret) begin
                        state      <= GUARD;
                        in_service <= 1'b0;
                        guard_cnt  <= GW'(GUARD_CYC);
                    end
                end
                GUARD: begin
                    if (guard_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        guard_cnt <= guard_cnt - 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    interrupt  <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_request_controller.sv
// Directed bench for interrupt_request_controller with a cycle model compared on every falling edge.
module tb_interrupt_request_controller;

    localparam int NUM_SRC   = 4;
    localparam int GUARD_CYC = 2;
`ifdef IRQ_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [NUM_SRC-1:0] irq_in = '0;
    logic [23:0]        ins = '0;
    logic               mask_wr = 1'b0;
    logic [NUM_SRC-1:0] mask_data = '0;
    logic               interrupt;
    logic [2:0]         int_src_id;
    logic               in_service;
    logic [NUM_SRC-1:0] pending;

    int checks = 0;
    int failures = 0;

    interrupt_request_controller #(
        .NUM_SRC  (NUM_SRC),
        .GUARD_CYC(GUARD_CYC),
        .MASK_RST (4'hF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .ins       (ins),
        .mask_wr   (mask_wr),
        .mask_data (mask_data),
        .interrupt (interrupt),
        .int_src_id(int_src_id),
        .in_service(in_service),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    // Reference model: delayed edge history, pending set, and a busy/guard timeline
    logic [NUM_SRC-1:0] m_dl [0:L+1];
    logic [NUM_SRC-1:0] m_pend;
    logic [NUM_SRC-1:0] m_mask;
    logic               m_pulse;
    logic               m_insvc;
    int                 m_guard;
    logic [2:0]         m_id;

    always @(posedge clk or negedge reset) begin : mdl
        logic [NUM_SRC-1:0] sh [0:L+1];
        logic [NUM_SRC-1:0] edg;
        logic [NUM_SRC-1:0] clr;
        logic [NUM_SRC-1:0] elig;
        logic               found;
        if (!reset) begin
            for (int j = 0; j <= L + 1; j++) m_dl[j] <= '0;
            m_pend  <= '0;
            m_mask  <= 4'hF;
            m_pulse <= 1'b0;
            m_insvc <= 1'b0;
            m_guard <= 0;
            m_id    <= '0;
        end else begin
            sh[0] = irq_in;
            for (int j = 1; j <= L + 1; j++) sh[j] = m_dl[j-1];
            edg = sh[L] & ~sh[L+1];
            clr = '0;
            if (m_pulse) begin
                m_pulse <= 1'b0;
            end else if (m_insvc) begin
                if (ins[23:19] == 5'b10000) begin
                    m_insvc <= 1'b0;
                    m_guard <= GUARD_CYC + 1;
                end
            end else if (m_guard > 0) begin
                m_guard <= m_guard - 1;
            end else begin
                elig = m_pend & m_mask;
                if (elig != '0 && ins[23] == 1'b0) begin
                    found = 1'b0;
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (elig[i] && !found) begin
                            found  = 1'b1;
                            clr[i] = 1'b1;
                            m_id  <= 3'(i);
                        end
                    end
                    m_pulse <= 1'b1;
                    m_insvc <= 1'b1;
                end
            end
            m_pend <= (m_pend & ~clr) | edg;
            if (mask_wr) m_mask <= mask_data;
            for (int j = 0; j <= L + 1; j++) m_dl[j] <= sh[j];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("cmp_interrupt", 32'(interrupt), 32'(m_pulse));
            chk("cmp_in_service", 32'(in_service), 32'(m_insvc));
            chk("cmp_pending", 32'(pending), 32'(m_pend));
            chk("cmp_int_src_id", 32'(int_src_id), 32'(m_id));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulse(input int budget, output int k);
        k = 0;
        while (k < budget) begin
            @(negedge clk);
            k++;
            if (interrupt === 1'b1) return;
        end
        checks++;
        failures++;
        $display("FAIL pulse_timeout: no interrupt within %0d cycles", budget);
        k = -1;
    endtask

    task automatic ret_cycle();
        ins = 24'h800000;
        @(negedge clk);
        ins = 24'h000000;
    endtask

    task automatic close_svc();
        step(1);
        ret_cycle();
        step(GUARD_CYC + 2);
    endtask

    task automatic write_mask(input logic [NUM_SRC-1:0] v);
        mask_data = v;
        mask_wr   = 1'b1;
        @(negedge clk);
        mask_wr   = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        #1 reset = 1'b0;
        #1;
        chk("rst_interrupt", 32'(interrupt), 32'h0);
        chk("rst_in_service", 32'(in_service), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_int_src_id", 32'(int_src_id), 32'h0);
        step(2);
        #2 reset = 1'b1;
        step(2);

        // Simple request on source 2
        irq_in = 4'b0100;
        wait_pulse(12, k);
        chk("simple_latency", 32'(k), 32'(L + 2));
        chk("simple_id", 32'(int_src_id), 32'd2);
        chk("simple_pending", 32'(pending), 32'h0);
        chk("simple_in_service", 32'(in_service), 32'h1);
        step(1);
        chk("simple_pulse_width", 32'(interrupt), 32'h0);
        close_svc();
        irq_in = 4'b0000;
        step(L + 2);

        // Priority: sources 3 and 1 together
        irq_in = 4'b1010;
        wait_pulse(12, k);
        chk("prio_first_id", 32'(int_src_id), 32'd1);
        chk("prio_pending", 32'(pending), 32'b1000);
        step(1);
        ret_cycle();
        chk("prio_ret_in_service", 32'(in_service), 32'h0);
        wait_pulse(12, k);
        chk("prio_guard_gap", 32'(k), 32'(GUARD_CYC + 2));
        chk("prio_second_id", 32'(int_src_id), 32'd3);
        close_svc();
        irq_in = 4'b0000;
        step(L + 2);

        // Hazard deferral behind a JMP in decode
        ins = 24'hC00010;
        irq_in = 4'b0001;
        step(L + 4);
        chk("hazard_no_pulse", 32'(interrupt), 32'h0);
        chk("hazard_pending", 32'(pending), 32'b0001);
        ins = 24'h000000;
        wait_pulse(8, k);
        chk("hazard_release_latency", 32'(k), 32'd1);
        chk("hazard_id", 32'(int_src_id), 32'd0);
        close_svc();
        irq_in = 4'b0000;
        step(L + 2);

        // Masking source 0
        write_mask(4'b1110);
        irq_in = 4'b0001;
        step(L + 4);
        chk("mask_pending_kept", 32'(pending), 32'b0001);
        chk("mask_no_service", 32'(in_service), 32'h0);
        write_mask(4'hF);
        wait_pulse(8, k);
        chk("unmask_latency", 32'(k), 32'd1);
        chk("unmask_id", 32'(int_src_id), 32'd0);
        close_svc();
        irq_in = 4'b0000;
        step(L + 2);

        // New edge on source 1 coincides with its grant
        ins = 24'hC00010;
        irq_in = 4'b0010;
        step(L + 2);
        irq_in = 4'b0000;
        step(L + 2);
        irq_in = 4'b0010;
        step(L);
        ins = 24'h000000;
        wait_pulse(8, k);
        chk("collide_latency", 32'(k), 32'd1);
        chk("collide_id", 32'(int_src_id), 32'd1);
        chk("collide_pending_set_wins", 32'(pending), 32'b0010);
        step(1);
        ret_cycle();
        wait_pulse(12, k);
        chk("collide_second_gap", 32'(k), 32'(GUARD_CYC + 2));
        chk("collide_second_id", 32'(int_src_id), 32'd1);
        chk("collide_pending_clear", 32'(pending), 32'h0);
        close_svc();
        irq_in = 4'b0000;
        step(L + 2);

        // Asynchronous reset in the middle of a service
        write_mask(4'b0111);
        irq_in = 4'b0100;
        wait_pulse(12, k);
        chk("pre_reset_id", 32'(int_src_id), 32'd2);
        irq_in = 4'b1100;
        step(L + 2);
        chk("pre_reset_pending", 32'(pending), 32'b1000);
        chk("pre_reset_in_service", 32'(in_service), 32'h1);
        irq_in = 4'b0000;
        step(L + 2);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_in_service", 32'(in_service), 32'h0);
        chk("async_rst_pending", 32'(pending), 32'h0);
        chk("async_rst_interrupt", 32'(interrupt), 32'h0);
        chk("async_rst_id", 32'(int_src_id), 32'h0);
        #1 reset = 1'b1;
        step(8);
        chk("post_reset_idle", 32'(in_service), 32'h0);
        irq_in = 4'b1000;
        wait_pulse(12, k);
        chk("post_reset_mask_latency", 32'(k), 32'(L + 2));
        chk("post_reset_mask_id", 32'(int_src_id), 32'd3);
        close_svc();
        irq_in = 4'b0000;
        step(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
